// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the pipeline control blocks: sequencer state and the hardwired zero register.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds rs1/rs2 of the instruction in ID.
// Purely combinational, no state.
module hazard_detect
    import cpu_ctrl_pkg::*;
(
    input  logic       mem_read,
    input  logic [4:0] rd_addr,
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    output logic       load_use
);

    // x0 is never a real dependency, so a load targeting it cannot stall ID.
    assign load_use = mem_read && (rd_addr != REG_ZERO) &&
                      ((rd_addr == rs1_addr) || (rd_addr == rs2_addr));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, ID branch flushes, data-memory req/ack freeze with timeout trap.
// Control outputs are same-cycle combinational; mem_req_o is registered; counters freeze once trapped.
module pipeline_hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic [4:0]       IFID_RS1addr_i,
    input  logic [4:0]       IFID_RS2addr_i,
    input  logic             Branch_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             PCWrite_o,
    output logic             Stall_o,
    output logic             Flush_o,
    output logic             NoOp_o,
    output logic             pipe_en_o,
    output logic             error_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              mem_op;
    logic              mem_stall;
    logic              load_use;

    assign mem_op      = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    hazard_detect u_hazard_detect (
        .mem_read (IDEX_MemRead_i),
        .rd_addr  (IDEX_RDaddr_i),
        .rs1_addr (IFID_RS1addr_i),
        .rs2_addr (IFID_RS2addr_i),
        .load_use (load_use)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:      if (mem_op) state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_nxt = ST_RUN;
                end else if (timeout_hit) begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_ERROR:    state_nxt = ST_ERROR;
            default:     state_nxt = ST_RUN;
        endcase
    end

    // On ack the pipe advances this same cycle, so the serviced op is gone before RUN samples mem_op again.
    always_comb begin
        mem_stall = ((state == ST_RUN) && mem_op) ||
                    ((state == ST_MEM_WAIT) && !mem_ack_i) ||
                    (state == ST_ERROR);
        pipe_en_o = !mem_stall;
        PCWrite_o = !mem_stall && !load_use;
        Stall_o   = mem_stall || load_use;
        NoOp_o    = !mem_stall && load_use;
        Flush_o   = !mem_stall && !load_use && Branch_i;
        error_o   = (state == ST_ERROR);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt  <= '0;
            mem_req_o <= 1'b0;
        end else begin
            mem_req_o <= (state_nxt == ST_MEM_WAIT);
            if (state == ST_RUN) begin
                wait_cnt <= '0;
            end else if ((state == ST_MEM_WAIT) && !mem_ack_i) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else if (state != ST_ERROR) begin
            if (Stall_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (Flush_o) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: the driver queues hand-computed per-cycle expectations, a monitor checks them mid-cycle.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic        req;
        logic        pcw;
        logic        stall;
        logic        flush;
        logic        noop;
        logic        pen;
        logic        err;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        IDEX_MemRead_i;
    logic [4:0]  IDEX_RDaddr_i;
    logic [4:0]  IFID_RS1addr_i;
    logic [4:0]  IFID_RS2addr_i;
    logic        Branch_i;
    logic        EXMEM_MemRead_i;
    logic        EXMEM_MemWrite_i;
    logic        mem_ack_i;
    logic        mem_req_o;
    logic        PCWrite_o;
    logic        Stall_o;
    logic        Flush_o;
    logic        NoOp_o;
    logic        pipe_en_o;
    logic        error_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    int   checks   = 0;
    int   failures = 0;
    int   cyc_id   = 0;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .IDEX_MemRead_i   (IDEX_MemRead_i),
        .IDEX_RDaddr_i    (IDEX_RDaddr_i),
        .IFID_RS1addr_i   (IFID_RS1addr_i),
        .IFID_RS2addr_i   (IFID_RS2addr_i),
        .Branch_i         (Branch_i),
        .EXMEM_MemRead_i  (EXMEM_MemRead_i),
        .EXMEM_MemWrite_i (EXMEM_MemWrite_i),
        .mem_ack_i        (mem_ack_i),
        .mem_req_o        (mem_req_o),
        .PCWrite_o        (PCWrite_o),
        .Stall_o          (Stall_o),
        .Flush_o          (Flush_o),
        .NoOp_o           (NoOp_o),
        .pipe_en_o        (pipe_en_o),
        .error_o          (error_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    function automatic exp_t E(input logic req, pcw, st, fl, no, pen, err,
                               input int s, input int f);
        exp_t e;
        e.req = req; e.pcw = pcw; e.stall = st; e.flush = fl; e.noop = no;
        e.pen = pen; e.err = err; e.scnt = s; e.fcnt = f;
        return e;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, id, got, want);
        end
    endtask

    task automatic drive(input logic ld, input logic [4:0] rd, rs1, rs2,
                         input logic br, mr, mw, ack);
        IDEX_MemRead_i   = ld;
        IDEX_RDaddr_i    = rd;
        IFID_RS1addr_i   = rs1;
        IFID_RS2addr_i   = rs2;
        Branch_i         = br;
        EXMEM_MemRead_i  = mr;
        EXMEM_MemWrite_i = mw;
        mem_ack_i        = ack;
    endtask

    task automatic step(input logic ld, input logic [4:0] rd, rs1, rs2,
                        input logic br, mr, mw, ack, input exp_t e);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        drive(ld, rd, rs1, rs2, br, mr, mw, ack);
        exp_q.push_back(e);
    endtask

    // Reset asserted between edges; its effect is checked before the next edge.
    task automatic areset(input logic mr, input exp_t e);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, mr, 1'b0, 1'b0);
        #1;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_req",   cyc_id, 32'(mem_req_o), 32'(e.req));
                chk("pc_write",  cyc_id, 32'(PCWrite_o), 32'(e.pcw));
                chk("stall",     cyc_id, 32'(Stall_o),   32'(e.stall));
                chk("flush",     cyc_id, 32'(Flush_o),   32'(e.flush));
                chk("noop",      cyc_id, 32'(NoOp_o),    32'(e.noop));
                chk("pipe_en",   cyc_id, 32'(pipe_en_o), 32'(e.pen));
                chk("error",     cyc_id, 32'(error_o),   32'(e.err));
                chk("stall_cnt", cyc_id, stall_cnt_o,    e.scnt);
                chk("flush_cnt", cyc_id, flush_cnt_o,    e.fcnt);
                cyc_id++;
            end
        end
    end

    initial begin
        rst_i = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        exp_q.push_back(E(0,1,0,0,0,1,0,0,0));

        // hazards: load-use, x0 destination, branch suppressed by load-use then taken
        step(0,0,0,0, 0,0,0,0, E(0,1,0,0,0,1,0,0,0));
        step(1,5,3,5, 0,0,0,0, E(0,0,1,0,1,1,0,0,0));
        step(1,0,0,0, 0,0,0,0, E(0,1,0,0,0,1,0,1,0));
        step(1,7,7,2, 1,0,0,0, E(0,0,1,0,1,1,0,1,0));
        step(0,7,0,0, 1,0,0,0, E(0,1,0,1,0,1,0,2,0));
        step(0,7,7,0, 0,0,0,0, E(0,1,0,0,0,1,0,2,1));

        // load in MEM with concurrent load-use and branch, ack on third wait cycle
        step(1,4,4,0, 1,1,0,0, E(0,0,1,0,0,0,0,2,1));
        step(0,0,0,0, 0,1,0,0, E(1,0,1,0,0,0,0,3,1));
        step(0,0,0,0, 0,1,0,0, E(1,0,1,0,0,0,0,4,1));
        step(0,0,0,0, 0,1,0,1, E(1,1,0,0,0,1,0,5,1));
        step(0,0,0,0, 0,0,0,1, E(0,1,0,0,0,1,0,5,1));

        // back-to-back stores, each with a fresh detect cycle and immediate ack
        step(0,0,0,0, 0,0,1,0, E(0,0,1,0,0,0,0,5,1));
        step(0,0,0,0, 0,0,1,1, E(1,1,0,0,0,1,0,6,1));
        step(0,0,0,0, 0,0,1,0, E(0,0,1,0,0,0,0,6,1));
        step(0,0,0,0, 0,0,1,1, E(1,1,0,0,0,1,0,7,1));
        step(0,0,0,0, 0,0,0,0, E(0,1,0,0,0,1,0,7,1));

        // timeout after four unacknowledged wait cycles
        step(0,0,0,0, 0,1,0,0, E(0,0,1,0,0,0,0,7,1));
        for (int k = 0; k < 4; k++)
            step(0,0,0,0, 0,1,0,0, E(1,0,1,0,0,0,0,8+k,1));
        step(0,0,0,0, 0,0,0,0, E(0,0,1,0,0,0,1,12,1));
        step(0,0,0,0, 1,0,0,1, E(0,0,1,0,0,0,1,12,1));
        step(0,0,0,0, 0,0,0,0, E(0,0,1,0,0,0,1,12,1));

        // reset out of ERROR, then reset in the middle of a memory wait
        areset(1'b0, E(0,1,0,0,0,1,0,0,0));
        step(0,0,0,0, 0,0,0,0, E(0,1,0,0,0,1,0,0,0));
        step(0,0,0,0, 0,1,0,0, E(0,0,1,0,0,0,0,0,0));
        step(0,0,0,0, 0,1,0,0, E(1,0,1,0,0,0,0,1,0));
        areset(1'b1, E(0,0,1,0,0,0,0,0,0));
        step(0,0,0,0, 0,1,0,0, E(0,0,1,0,0,0,0,0,0));
        step(0,0,0,0, 0,1,0,1, E(1,1,0,0,0,1,0,1,0));
        step(0,0,0,0, 0,0,0,0, E(0,1,0,0,0,1,0,1,0));

        repeat (3) @(posedge clk_i);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards and ID-stage taken branches.
- Runs a req/ack handshake with a multi-cycle data memory and freezes the whole pipe while it is outstanding.
- Traps memory timeouts and exposes stall/flush performance counters.
- Sits beside the hazard path in the CPU top level and drives PC write enable, IF/ID Stall_i/Flush_i, the ID/EX bubble mux and the register enables downstream of ID/EX.

Parameters:
MEM_TIMEOUT, 255, max MEM_WAIT cycles without ack before ERROR; 0 disables timeout.
CNT_W, 32, width of performance counters.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_RDaddr_i  in  5  destination register of instruction in EX
IFID_RS1addr_i  in  5  rs1 of instruction in ID
IFID_RS2addr_i  in  5  rs2 of instruction in ID
Branch_i  in  1  branch resolved taken in ID this cycle
EXMEM_MemRead_i  in  1  load in MEM stage
EXMEM_MemWrite_i  in  1  store in MEM stage
mem_ack_i  in  1  data memory completion, one-cycle pulse
mem_req_o  out  1  data memory request, held until ack
PCWrite_o  out  1  PC register enable
Stall_o  out  1  IF/ID hold
Flush_o  out  1  IF/ID clear to NOP
NoOp_o  out  1  zero ID/EX control fields (bubble)
pipe_en_o  out  1  enable for ID/EX, EX/MEM, MEM/WB
error_o  out  1  sticky memory-timeout flag
stall_cnt_o  out  CNT_W  cycles with Stall_o=1
flush_cnt_o  out  CNT_W  cycles with Flush_o=1

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR.
- Reset (rst_i=0, async): state=RUN, wait counter=0, error_o=0, stall_cnt_o=0, flush_cnt_o=0, mem_req_o=0. Reset mid-MEM_WAIT drops mem_req_o immediately.
- mem_op = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- mem_stall = (RUN & mem_op) | (MEM_WAIT & ~mem_ack_i) | ERROR.
- load_use = IDEX_MemRead_i & (IDEX_RDaddr_i != 0) & (IDEX_RDaddr_i == IFID_RS1addr_i | IDEX_RDaddr_i == IFID_RS2addr_i).
- Combinational outputs, same-cycle:
  - pipe_en_o = ~mem_stall
  - PCWrite_o = ~mem_stall & ~load_use
  - Stall_o = mem_stall | load_use
  - NoOp_o = ~mem_stall & load_use
  - Flush_o = ~mem_stall & ~load_use & Branch_i
- Priority: mem_stall > load_use > branch flush. A branch during load-use is ignored this cycle and re-evaluated next cycle.
- Transitions:
  - RUN -> MEM_WAIT when mem_op. Wait counter cleared.
  - MEM_WAIT & mem_ack_i -> RUN. The pipe advances in that same cycle, so the serviced instruction leaves EX/MEM and is not re-requested.
  - MEM_WAIT & ~mem_ack_i: counter += 1. If MEM_TIMEOUT != 0 and counter == MEM_TIMEOUT-1, go to ERROR next cycle.
  - ERROR: absorbing until reset. error_o=1.
- mem_req_o = registered, 1 exactly while state == MEM_WAIT.
- Minimum cost of a memory op is 2 cycles: 1 detect cycle plus ack in the first MEM_WAIT cycle.
- Back-to-back memory ops each pay a fresh RUN detect cycle.
- mem_ack_i outside MEM_WAIT is ignored.
- Counters increment on the clock edge when their output is 1, wrap modulo 2^CNT_W, and freeze in ERROR.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - state encoding: ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERROR=2'd2
  - REG_ZERO=5'd0
- One sub-module, hazard_detect: purely combinational load_use comparator.
- FSM, counters and output equations live in the top module.

Test Plan:
1. Reset release, no hazards: Stall_o=0, Flush_o=0, NoOp_o=0, PCWrite_o=1, pipe_en_o=1, counters 0.
2. IDEX_MemRead_i=1, RDaddr=5, IFID RS2=5: Stall_o=1, NoOp_o=1, PCWrite_o=0, pipe_en_o=1; stall_cnt_o=1 after edge. Repeat with RDaddr=0: no stall.
3. Load-use and Branch_i together: Flush_o=0. Next cycle with load_use cleared and Branch_i=1: Flush_o=1, flush_cnt_o increments.
4. EXMEM_MemRead_i=1, ack after 3 MEM_WAIT cycles:
   - cycle 0 (RUN): pipe_en_o=0, mem_req_o=0
   - cycles 1-3: mem_req_o=1
   - cycle 3 with ack: pipe_en_o=1; state RUN next cycle
   - stall_cnt_o=3
5. MEM_TIMEOUT=4, no ack: mem_req_o high 4 cycles, then error_o=1, mem_req_o=0, pipe_en_o=0 permanently. A later stray ack changes nothing.
6. rst_i asserted mid-MEM_WAIT (asynchronous, between edges): mem_req_o=0 and counters=0 immediately; after release, state RUN.
